// File: rtl/imsic_pkg.sv
// Shared definitions for the IMSIC MSI ingress path.
//
// Contents:
//   - AXI4-Lite request/response structs seen by the MSI ingress port.
//     The read channel carries no address because every read returns zero.
//   - Page geometry and seteipnum register offsets.
//   - Byte-swap helper used by the big-endian seteipnum register.
package imsic_pkg;

    localparam int unsigned AXI_BUS_ADDR_W = 64;
    localparam int unsigned AXI_BUS_DATA_W = 64;
    localparam int unsigned AXI_BUS_ID_W   = 10;

    localparam int unsigned PAGE_SHIFT       = 12;
    localparam logic [31:0] PAGE_STRIDE      = 32'h1000;
    localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
    localparam logic [11:0] SETEIPNUM_BE_OFF = 12'h004;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef struct packed {
        logic                      aw_valid;
        logic [AXI_BUS_ADDR_W-1:0] aw_addr;
        logic [AXI_BUS_ID_W-1:0]   aw_id;
        logic                      w_valid;
        logic [AXI_BUS_DATA_W-1:0] w_data;
        logic                      b_ready;
        logic                      ar_valid;
        logic [AXI_BUS_ID_W-1:0]   ar_id;
        logic                      r_ready;
    } axi_req_t;

    typedef struct packed {
        logic                      aw_ready;
        logic                      w_ready;
        logic                      b_valid;
        logic [AXI_BUS_ID_W-1:0]   b_id;
        logic [1:0]                b_resp;
        logic                      ar_ready;
        logic                      r_valid;
        logic [AXI_BUS_ID_W-1:0]   r_id;
        logic [AXI_BUS_DATA_W-1:0] r_data;
        logic [1:0]                r_resp;
    } axi_resp_t;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Circular FIFO holding accepted MSIs until the interrupt files take them.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the queue)
//   push        write push_data when not full, or when full and a pop
//               happens in the same cycle
//   push_data   entry to store
//   pop         remove the head entry (ignored when empty)
//   head_data   current head entry, zero while empty
//   full/empty  occupancy flags
//   level       number of stored entries (0..DEPTH)
module imsic_msi_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB is a wrap bit: equal indices with different wrap bits = full.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = push && (!full || do_pop);
    assign level   = wr_ptr - rd_ptr;

    // Masking keeps the head at zero whenever the queue holds nothing.
    assign head_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define
    // which slots are meaningful and the head mask hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/imsic_seteipnum_queue.sv
// MSI ingress for the IMSIC: decodes AXI4-Lite writes to the seteipnum_le /
// seteipnum_be registers of the M-level and S/VS-level interrupt-file pages,
// validates the identity and queues accepted MSIs for the interrupt files.
//
// Ports:
//   i_clk, ni_rst     clock, asynchronous active-low reset
//   i_req / o_resp    AXI4-Lite slave; every write answers OKAY, reads return 0
//   o_msi_valid       queue head valid
//   i_msi_ready       interrupt file accepts the head this cycle
//   o_msi_hart/file/id  head target (file 0 = M, 1 = S, 2.. = VS1..)
//   o_level           queue occupancy
//   i_cnt_clr         synchronous clear of both counters (wins over increment)
//   o_drop_cnt        saturating count of MSIs lost to a full queue
//   o_inval_cnt       saturating count of seteipnum writes with an invalid ID
module imsic_seteipnum_queue
    import imsic_pkg::*;
#(
    parameter int unsigned NR_SRC                = 64,
    parameter logic [31:0] IMSIC_M_BASE_ADDR     = 32'h24000000,
    parameter logic [31:0] IMSIC_S_BASE_ADDR     = 32'h28000000,
    parameter int unsigned AXI_DATA_WIDTH        = 64,
    parameter int unsigned NR_IMSICS             = 1,
    parameter int unsigned NR_VS_FILES_PER_IMSIC = 0,
    parameter int unsigned FIFO_DEPTH            = 4,
    localparam int unsigned NR_INTP_FILES = 2 + NR_VS_FILES_PER_IMSIC,
    localparam int unsigned ID_W          = $clog2(NR_SRC),
    localparam int unsigned HART_W        = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
    localparam int unsigned FILE_W        = $clog2(NR_INTP_FILES),
    localparam int unsigned LEVEL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                i_clk,
    input  logic                ni_rst,
    input  axi_req_t            i_req,
    output axi_resp_t           o_resp,
    output logic                o_msi_valid,
    input  logic                i_msi_ready,
    output logic [HART_W-1:0]   o_msi_hart,
    output logic [FILE_W-1:0]   o_msi_file,
    output logic [ID_W-1:0]     o_msi_id,
    output logic [LEVEL_W-1:0]  o_level,
    input  logic                i_cnt_clr,
    output logic [15:0]         o_drop_cnt,
    output logic [15:0]         o_inval_cnt
);

    typedef struct packed {
        logic [HART_W-1:0] hart;
        logic [FILE_W-1:0] file;
        logic [ID_W-1:0]   id;
    } msi_entry_t;

    localparam int unsigned ENTRY_W = $bits(msi_entry_t);

    localparam logic [19:0] M_BASE_PAGE     = IMSIC_M_BASE_ADDR[31:PAGE_SHIFT];
    localparam logic [19:0] S_BASE_PAGE     = IMSIC_S_BASE_ADDR[31:PAGE_SHIFT];
    localparam logic [31:0] NR_M_PAGES      = 32'(NR_IMSICS);
    localparam logic [31:0] S_PAGES_PER_HART = 32'(1 + NR_VS_FILES_PER_IMSIC);
    localparam logic [31:0] NR_S_PAGES      = 32'(NR_IMSICS * (1 + NR_VS_FILES_PER_IMSIC));
    localparam logic [31:0] NR_SRC_32       = 32'(NR_SRC);

    // ---------------- AXI4-Lite front end ----------------
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    b_valid_q;
    logic                    r_valid_q;
    logic [AXI_BUS_ID_W-1:0] b_id_q;
    logic [AXI_BUS_ID_W-1:0] r_id_q;

    // A write is taken when address and data are both present and the B slot
    // is free or being drained, so a ready master sees one write per cycle.
    assign wr_fire = i_req.aw_valid && i_req.w_valid && (!b_valid_q || i_req.b_ready);
    assign rd_fire = i_req.ar_valid && (!r_valid_q || i_req.r_ready);

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            b_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            b_id_q    <= '0;
            r_id_q    <= '0;
        end else begin
            if (wr_fire) begin
                b_valid_q <= 1'b1;
                b_id_q    <= i_req.aw_id;
            end else if (i_req.b_ready) begin
                b_valid_q <= 1'b0;
            end
            if (rd_fire) begin
                r_valid_q <= 1'b1;
                r_id_q    <= i_req.ar_id;
            end else if (i_req.r_ready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        o_resp          = '0;
        o_resp.aw_ready = wr_fire;
        o_resp.w_ready  = wr_fire;
        o_resp.b_valid  = b_valid_q;
        o_resp.b_id     = b_id_q;
        o_resp.b_resp   = AXI_RESP_OKAY;
        o_resp.ar_ready = !r_valid_q || i_req.r_ready;
        o_resp.r_valid  = r_valid_q;
        o_resp.r_id     = r_id_q;
        o_resp.r_data   = '0;
        o_resp.r_resp   = AXI_RESP_OKAY;
    end

    // ---------------- page / register decode ----------------
    logic [31:0]       m_page;
    logic [31:0]       s_page;
    logic              page_hit;
    logic [HART_W-1:0] tgt_hart;
    logic [FILE_W-1:0] tgt_file;
    logic [11:0]       offset;
    logic [31:0]       lane_be;
    logic [31:0]       msi_id;
    logic              seteip_wr;
    logic              id_ok;

    // Addresses below a base wrap to huge page numbers and miss the range.
    assign m_page = {12'h0, i_req.aw_addr[31:PAGE_SHIFT] - M_BASE_PAGE};
    assign s_page = {12'h0, i_req.aw_addr[31:PAGE_SHIFT] - S_BASE_PAGE};
    assign offset = i_req.aw_addr[PAGE_SHIFT-1:0];

    // NOTE: every signal written in a combinational block gets a default at
    // the top so that no path leaves it unassigned and infers a latch.
    always_comb begin
        page_hit = 1'b0;
        tgt_hart = '0;
        tgt_file = '0;
        if (i_req.aw_addr[63:32] == 32'h0) begin
            if (m_page < NR_M_PAGES) begin
                page_hit = 1'b1;
                tgt_hart = HART_W'(m_page);
            end else if (s_page < NR_S_PAGES) begin
                page_hit = 1'b1;
                tgt_hart = HART_W'(s_page / S_PAGES_PER_HART);
                tgt_file = FILE_W'((s_page % S_PAGES_PER_HART) + 32'd1);
            end
        end
    end

    // Offset 4 is the upper lane on a 64-bit bus, the only lane on 32-bit.
    assign lane_be = (AXI_DATA_WIDTH == 64) ? i_req.w_data[63:32] : i_req.w_data[31:0];
    assign msi_id  = (offset == SETEIPNUM_BE_OFF) ? bswap32(lane_be) : i_req.w_data[31:0];

    assign seteip_wr = wr_fire && page_hit &&
                       ((offset == SETEIPNUM_LE_OFF) || (offset == SETEIPNUM_BE_OFF));
    assign id_ok     = (msi_id != 32'h0) && (msi_id < NR_SRC_32);

    // ---------------- queue ----------------
    msi_entry_t push_entry;
    msi_entry_t head_entry;
    logic       push_req;
    logic       pop_fire;
    logic       fifo_full;
    logic       fifo_empty;

    assign push_req   = seteip_wr && id_ok;
    assign push_entry = '{hart: tgt_hart, file: tgt_file, id: msi_id[ID_W-1:0]};
    assign pop_fire   = o_msi_valid && i_msi_ready;

    imsic_msi_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (ni_rst),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (i_msi_ready),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_level)
    );

    assign o_msi_valid = !fifo_empty;
    assign o_msi_hart  = head_entry.hart;
    assign o_msi_file  = head_entry.file;
    assign o_msi_id    = head_entry.id;

    // ---------------- accounting ----------------
    logic drop_inc;
    logic inval_inc;

    assign drop_inc  = push_req && fifo_full && !pop_fire;
    assign inval_inc = seteip_wr && !id_ok;

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            o_drop_cnt  <= '0;
            o_inval_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_drop_cnt  <= '0;
            o_inval_cnt <= '0;
        end else begin
            if (drop_inc && (o_drop_cnt != 16'hFFFF))   o_drop_cnt  <= o_drop_cnt + 16'd1;
            if (inval_inc && (o_inval_cnt != 16'hFFFF)) o_inval_cnt <= o_inval_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_imsic_seteipnum_queue.sv
// Directed self-checking bench for imsic_seteipnum_queue (4 harts, 1 VS file
// per hart, 4-entry queue). Expected MSIs are pushed to a scoreboard as the
// writes are issued and compared as the queue head is consumed.
module tb_imsic_seteipnum_queue;
    import imsic_pkg::*;

    localparam logic [31:0] M_BASE = 32'h24000000;
    localparam logic [31:0] S_BASE = 32'h28000000;

    logic        i_clk = 1'b0;
    logic        ni_rst;
    axi_req_t    req;
    axi_resp_t   resp;
    logic        msi_valid;
    logic        msi_ready;
    logic [1:0]  msi_hart;
    logic [1:0]  msi_file;
    logic [5:0]  msi_id;
    logic [2:0]  level;
    logic        cnt_clr;
    logic [15:0] drop_cnt;
    logic [15:0] inval_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned hart;
        int unsigned file;
        int unsigned id;
    } msi_t;

    msi_t sb[$];

    always #5 i_clk = ~i_clk;

    imsic_seteipnum_queue #(
        .NR_IMSICS             (4),
        .NR_VS_FILES_PER_IMSIC (1),
        .FIFO_DEPTH            (4)
    ) dut (
        .i_clk       (i_clk),
        .ni_rst      (ni_rst),
        .i_req       (req),
        .o_resp      (resp),
        .o_msi_valid (msi_valid),
        .i_msi_ready (msi_ready),
        .o_msi_hart  (msi_hart),
        .o_msi_file  (msi_file),
        .o_msi_id    (msi_id),
        .o_level     (level),
        .i_cnt_clr   (cnt_clr),
        .o_drop_cnt  (drop_cnt),
        .o_inval_cnt (inval_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [63:0] data);
        req.aw_valid = 1'b1;
        req.aw_addr  = {32'h0, addr};
        req.aw_id    = addr[9:0];
        req.w_valid  = 1'b1;
        req.w_data   = data;
    endtask

    task automatic end_write();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [63:0] data);
        start_write(addr, data);
        tick();
        end_write();
    endtask

    task automatic expect_msi(input int unsigned hart, input int unsigned file, input int unsigned id);
        msi_t e;
        e.hart = hart;
        e.file = file;
        e.id   = id;
        sb.push_back(e);
    endtask

    // Compare the head against the scoreboard front, then consume it.
    task automatic pop_expect(input string tag);
        msi_t e;
        int   waited = 0;
        while (!msi_valid && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, 32'(msi_valid), 32'd1);
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s_scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_hart"}, 32'(msi_hart), e.hart);
            check({tag, "_file"}, 32'(msi_file), e.file);
            check({tag, "_id"},   32'(msi_id),   e.id);
        end
        msi_ready = 1'b1;
        tick();
        msi_ready = 1'b0;
    endtask

    initial begin
        msi_t e;
        req         = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        msi_ready   = 1'b0;
        cnt_clr     = 1'b0;
        ni_rst      = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(msi_valid), 32'd0);
        check("rst_hart",  32'(msi_hart),  32'd0);
        check("rst_file",  32'(msi_file),  32'd0);
        check("rst_id",    32'(msi_id),    32'd0);
        check("rst_level", 32'(level),     32'd0);
        check("rst_drop",  32'(drop_cnt),  32'd0);
        check("rst_inval", 32'(inval_cnt), 32'd0);
        ni_rst = 1'b1;
        tick();

        // S page 3 -> hart 1, VS1 (file 2); head appears the cycle after push
        expect_msi(1, 2, 5);
        start_write(S_BASE + 32'h3000, 64'd5);
        check("s_no_fallthrough", 32'(msi_valid), 32'd0);
        tick();
        end_write();
        check("s_valid_next",  32'(msi_valid),   32'd1);
        check("s_b_valid",     32'(resp.b_valid), 32'd1);
        check("s_b_resp",      32'(resp.b_resp),  32'(AXI_RESP_OKAY));
        check("s_b_id",        32'(resp.b_id),    32'h000);
        check("s_level",       32'(level),        32'd1);
        pop_expect("s_p3");
        check("s_level_empty", 32'(level),        32'd0);

        // Big-endian register on M page 2, upper lane of the 64-bit bus
        expect_msi(2, 0, 10);
        axi_write(M_BASE + 32'h2004, {32'h0A000000, 32'h0});
        pop_expect("m_be");

        // Little-endian ignores the upper lane; S page 6 -> hart 3, file 1, max id
        expect_msi(1, 0, 7);
        axi_write(M_BASE + PAGE_STRIDE, {32'hFFFF_FFFF, 32'd7});
        expect_msi(3, 1, 63);
        axi_write(S_BASE + 32'h6000, 64'd63);
        pop_expect("m_le_hiignored");
        pop_expect("s_p6_id63");

        // Invalid identities: 0 and NR_SRC
        axi_write(M_BASE, 64'd0);
        axi_write(M_BASE, 64'd64);
        check("inval_cnt2",   32'(inval_cnt), 32'd2);
        check("inval_nomsi",  32'(msi_valid), 32'd0);

        // Ignored: unknown offset, M page past last hart, S page past last file
        axi_write(M_BASE + 32'h008, 64'd5);
        axi_write(M_BASE + 32'h4000, 64'd5);
        axi_write(S_BASE + 32'h8000, 64'd5);
        tick();
        check("ignored_level", 32'(level),     32'd0);
        check("ignored_inval", 32'(inval_cnt), 32'd2);
        check("ignored_drop",  32'(drop_cnt),  32'd0);

        // Six writes into a stalled 4-entry queue
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_msi(0, 0, 11 + i);
            axi_write(M_BASE, 64'(11 + i));
        end
        check("full_level", 32'(level),    32'd4);
        check("full_drop",  32'(drop_cnt), 32'd2);

        // Full queue, push and pop in the same cycle
        e = sb.pop_front();
        check("pp_head_id", 32'(msi_id), e.id);
        expect_msi(0, 0, 20);
        start_write(M_BASE, 64'd20);
        msi_ready = 1'b1;
        tick();
        end_write();
        msi_ready = 1'b0;
        check("pp_level", 32'(level),    32'd4);
        check("pp_drop",  32'(drop_cnt), 32'd2);

        // Back-to-back drain keeps FIFO order
        pop_expect("drain0");
        pop_expect("drain1");
        pop_expect("drain2");
        pop_expect("drain3");
        check("drain_level", 32'(level), 32'd0);

        // Counter clear, then saturate the drop counter
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_drop",  32'(drop_cnt),  32'd0);
        check("clr_inval", 32'(inval_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_msi(0, 0, 21 + i);
            axi_write(M_BASE, 64'(21 + i));
        end
        start_write(M_BASE, 64'd25);
        repeat (65535) tick();
        check("sat_reach", 32'(drop_cnt), 32'hFFFF);
        tick();
        check("sat_hold",  32'(drop_cnt), 32'hFFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        end_write();
        check("clr_wins",  32'(drop_cnt), 32'd0);
        check("sat_level", 32'(level),    32'd4);

        // Reset with three entries queued acts immediately
        pop_expect("pre_rst");
        check("pre_rst_level", 32'(level), 32'd3);
        #2;
        ni_rst = 1'b0;
        #1;
        check("arst_valid", 32'(msi_valid), 32'd0);
        check("arst_level", 32'(level),     32'd0);
        check("arst_id",    32'(msi_id),    32'd0);
        tick();
        ni_rst = 1'b1;
        sb.delete();
        tick();

        // Reads return zero and do not disturb the queue
        for (int i = 0; i < 3; i++) begin
            req.ar_valid = 1'b1;
            req.ar_id    = 10'(i * 7 + 1);
            tick();
            req.ar_valid = 1'b0;
            check("rd_valid", 32'(resp.r_valid), 32'd1);
            check("rd_data",  resp.r_data[31:0], 32'd0);
            check("rd_data_hi", resp.r_data[63:32], 32'd0);
            check("rd_id",    32'(resp.r_id),    32'(i * 7 + 1));
        end
        check("rd_level", 32'(level), 32'd0);

        // Queue works after reset; minimum valid id on S page 0
        expect_msi(0, 1, 1);
        axi_write(S_BASE, 64'd1);
        pop_expect("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imsic_seteipnum_queue.md
# imsic_seteipnum_queue

Parametrised MSI ingress block for the IMSIC: decodes AXI4-Lite writes to the M-level and S/VS-level interrupt-file pages of up to NR_IMSICS harts, supports both seteipnum_le and seteipnum_be, validates identities, and buffers accepted MSIs in a FIFO drained by a valid/ready port towards the interrupt files. It replaces the purely combinational write decode with a buffered path, arbitrary VS-file counts and drop/invalid accounting. It sits between the AIA AXI slave port and the per-hart interrupt-file array.

## Interface
- NR_SRC, 64: identities per interrupt file; valid IDs are 1..NR_SRC-1.
- IMSIC_M_BASE_ADDR, 32'h24000000: base of the M-level pages.
- IMSIC_S_BASE_ADDR, 32'h28000000: base of the S/VS-level pages.
- AXI_ADDR_WIDTH, 64; AXI_DATA_WIDTH, 64 (32 or 64 supported); AXI_ID_WIDTH, 10.
- NR_IMSICS, 1: number of harts/IMSICs (1..16).
- NR_VS_FILES_PER_IMSIC, 0: guest files per hart (0..63).
- FIFO_DEPTH, 4: MSI queue depth (power of two, ≥2).
- Derived, not overridable: NR_INTP_FILES = 2 + NR_VS_FILES_PER_IMSIC; ID_W = $clog2(NR_SRC); HART_W, FILE_W = max(1, $clog2(count)).
- axi_req_t / axi_resp_t: ariane_axi::req_t / resp_t.
- i_clk  in  1  clock.
- ni_rst  in  1  asynchronous active-low reset.
- i_req  in  axi_req_t  AXI4-Lite request.
- o_resp  out  axi_resp_t  AXI4-Lite response.
- o_msi_valid  out  1  queue head valid.
- i_msi_ready  in  1  interrupt file accepts head.
- o_msi_hart  out  HART_W  target IMSIC index.
- o_msi_file  out  FILE_W  target file (0 = M, 1 = S, 2.. = VS1..).
- o_msi_id  out  ID_W  interrupt identity.
- o_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- i_cnt_clr  in  1  synchronous clear of both counters.
- o_drop_cnt  out  16  saturating count of MSIs lost to a full queue.
- o_inval_cnt  out  16  saturating count of writes with invalid ID.

## Operation
- AXI conversion via aia_axi_lite_interface (address, en, we, wdata, rdata); writes never stall; all reads return 0, no side effect.
- Page = address[31:12] relative to base; offset = address[11:0].
- M region: page p in 0..NR_IMSICS-1 → hart p, file 0.
- S region: page p in 0..NR_IMSICS*(1+NR_VS_FILES_PER_IMSIC)-1 → hart = p/(1+NR_VS), g = p%(1+NR_VS), file = g+1.
- Offset 0x000 seteipnum_le: id = 32-bit lane at offset 0. Offset 0x004 seteipnum_be: id = byte-swap of lane at offset 4 (wdata[63:32] on a 64-bit bus, wdata[31:0] on 32-bit). Other offsets, pages outside both regions: ignored, nothing counted.
- Full 32-bit id checked: id==0 or id≥NR_SRC → no push, o_inval_cnt+1.
- Valid write pushes {hart, file, id[ID_W-1:0]}; full queue without a pop the same cycle → discard, o_drop_cnt+1.
- Push and pop in same cycle: both occur; when full, push accepted because pop frees the slot; level unchanged.
- Counters saturate at 16'hFFFF; i_cnt_clr wins over a same-cycle increment.
- Queue strictly FIFO; no merging of duplicate MSIs.

## Timing
- Reset: queue empty, o_msi_valid=0, o_msi_hart/file/id=0, o_level=0, both counters 0; reset mid-operation discards all queued entries.
- Push→o_msi_valid: 1 cycle (registered, no fall-through).
- Pop on o_msi_valid && i_msi_ready; next entry presented the following cycle; back-to-back pops sustain 1 MSI/cycle.
- Head fields stable while o_msi_valid && !i_msi_ready.
- o_level and counters update in the cycle after the event.
- AXI response timing is that of aia_axi_lite_interface; B response OKAY for every write, including dropped/ignored.

## Structure
- Package imsic_pkg: page stride 'h1000, SETEIPNUM_LE_OFF 'h000, SETEIPNUM_BE_OFF 'h004, msi_entry_t struct template widths, byte-swap function.
- Sub-module imsic_msi_fifo: parametric circular FIFO (pointers with wrap bit, level output, push/pop, full/empty).
- Top holds decode, ID check, counters.

## Test plan
- NR_IMSICS=4, NR_VS=1: write 5 to S_BASE+0x3000 → single MSI hart 1, file 2, id 5, valid one cycle after push.
- Write 32'h0A000000 to M_BASE+0x2004 (be) → hart 2, file 0, id 10; write 0 or 64 to M_BASE → no MSI, o_inval_cnt=2.
- i_msi_ready=0, 6 valid writes, FIFO_DEPTH=4 → o_level=4, o_drop_cnt=2, then draining yields first 4 IDs in order.
- Full queue, push and pop same cycle → push accepted, o_level stays 4, o_drop_cnt unchanged.
- Counter at 16'hFFFF plus drop → stays 16'hFFFF; i_cnt_clr with increment → 0.
- Reset asserted with 3 entries queued → o_msi_valid=0, o_level=0 asynchronously; reads anywhere return 0.
